// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between core datapath and unified memory
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter reload value: WAIT lasts MEM_LATENCY cycles, capturing when it reaches 0.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [1:0]  cnt;

  logic        req_fault;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign busy = (state != S_IDLE);

  // Reject unknown sizes and misaligned half/word accesses before touching memory.
  always_comb begin
    req_fault = 1'b0;
    case (funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = addr[0];
      3'b010:  req_fault = (addr[1:0] != 2'b00);
      3'b100:  req_fault = we;
      3'b101:  req_fault = we | addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // Store byte lanes and replicated data so the active lanes carry the operand.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << addr[1:0];
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  // Move the addressed lane down to bit 0 and extend it according to the load type.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Access sequencer: one request per pass through IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      cnt       <= 2'b00;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'h0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      done   <= 1'b0;
      fault  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q     <= we;
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            if (req_fault) begin
              state <= S_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              mem_en    <= 1'b1;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_we    <= we ? st_we : 4'b0000;
              mem_wdata <= st_wdata;
            end
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (cnt == 2'b00) begin
            rdata <= load_ext;
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 2'b01;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit at latency 1 and 3
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] mem_word = 32'h0;

  logic        busy1, done1, fault1, mem_en1;
  logic [3:0]  mem_we1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        busy3, done3, fault3, mem_en3;
  logic [3:0]  mem_we3;
  logic [31:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_access_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .fault(fault1), .rdata(rdata1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_access_unit #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy3), .done(done3), .fault(fault3), .rdata(rdata3), .mem_en(mem_en3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Memory model: read word is valid exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
  logic       sr1 = 1'b0;
  logic [2:0] sr3 = 3'b000;
  always @(posedge clk) begin
    sr1 <= mem_en1;
    sr3 <= {sr3[1:0], mem_en3};
  end
  assign mem_rdata1 = sr1    ? mem_word : 32'h5A5A5A5A;
  assign mem_rdata3 = sr3[2] ? mem_word : 32'h5A5A5A5A;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic [1:0]  kind;    // 0 store, 1 load, 2 rejected
    logic [3:0]  ewe;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;

  localparam int NV = 23;
  vec_t        vt [NV];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [31:0] ea, er;
    logic [3:0]  ewe;
    int          e1, e3, c1, c3, n1, n3, d1, d3, bw, ed, eds;
    v   = vt[idx];
    ea  = {v.addr[31:2], 2'b00};
    er  = (v.kind == 2'd1) ? v.erdata : exp_rd;
    ewe = (v.kind == 2'd0) ? v.ewe : 4'h0;
    e1 = 0; e3 = 0; c1 = 0; c3 = 0; n1 = 0; n3 = 0; d1 = 0; d3 = 0; bw = 0;
    @(negedge clk);
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; mem_word = v.word;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d busy1", idx), 32'(busy1), 32'd1);
        chk($sformatf("v%0d busy3", idx), 32'(busy3), 32'd1);
        req = 1'b0;
      end
      if (mem_en1) begin
        e1++; c1 = c;
        chk($sformatf("v%0d mem_we1", idx), 32'(mem_we1), 32'(ewe));
        chk($sformatf("v%0d mem_addr1", idx), mem_addr1, ea);
        if (v.kind == 2'd0) chk($sformatf("v%0d mem_wdata1", idx), mem_wdata1, v.ewdata);
      end
      if (mem_en3) begin
        e3++; c3 = c;
        chk($sformatf("v%0d mem_we3", idx), 32'(mem_we3), 32'(ewe));
        chk($sformatf("v%0d mem_addr3", idx), mem_addr3, ea);
        if (v.kind == 2'd0) chk($sformatf("v%0d mem_wdata3", idx), mem_wdata3, v.ewdata);
      end
      if (!mem_en1 && mem_we1 != 4'h0) bw++;
      if (!mem_en3 && mem_we3 != 4'h0) bw++;
      if (done1) begin
        n1++; d1 = c;
        chk($sformatf("v%0d fault1", idx), 32'(fault1), 32'(v.kind == 2'd2));
        chk($sformatf("v%0d rdata1", idx), rdata1, er);
      end
      if (done3) begin
        n3++; d3 = c;
        chk($sformatf("v%0d fault3", idx), 32'(fault3), 32'(v.kind == 2'd2));
        chk($sformatf("v%0d rdata3", idx), rdata3, er);
      end
    end
    ed  = (v.kind == 2'd2) ? 1 : (v.kind == 2'd0) ? 2 : 3;
    eds = (v.kind == 2'd1) ? 5 : ed;
    chk($sformatf("v%0d done1 count", idx), n1, 1);
    chk($sformatf("v%0d done1 cycle", idx), d1, ed);
    chk($sformatf("v%0d done3 count", idx), n3, 1);
    chk($sformatf("v%0d done3 cycle", idx), d3, eds);
    chk($sformatf("v%0d mem_en1 count", idx), e1, (v.kind == 2'd2) ? 0 : 1);
    chk($sformatf("v%0d mem_en3 count", idx), e3, (v.kind == 2'd2) ? 0 : 1);
    if (v.kind != 2'd2) begin
      chk($sformatf("v%0d mem_en1 cycle", idx), c1, 1);
      chk($sformatf("v%0d mem_en3 cycle", idx), c3, 1);
    end
    chk($sformatf("v%0d stray mem_we", idx), bw, 0);
    chk($sformatf("v%0d idle busy1", idx), 32'(busy1), 32'd0);
    chk($sformatf("v%0d idle busy3", idx), 32'(busy3), 32'd0);
    exp_rd = er;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e1, e3, n1, n3, en4;

    //        we    f3      addr         wdata          word           kind  ewe   ewdata         erdata
    vt[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2'd0, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        2'd0, 4'h8, 32'hA5A5A5A5, 32'h0};
    vt[2]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        2'd0, 4'hC, 32'h12341234, 32'h0};
    vt[3]  = '{1'b1, 3'b000, 32'h100, 32'h12345677, 32'h0,        2'd0, 4'h1, 32'h77777777, 32'h0};
    vt[4]  = '{1'b1, 3'b001, 32'h100, 32'hABCDBEEF, 32'h0,        2'd0, 4'h3, 32'hBEEFBEEF, 32'h0};
    vt[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h123480FF, 2'd1, 4'h0, 32'h0,        32'hFFFFFF80};
    vt[6]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h123480FF, 2'd1, 4'h0, 32'h0,        32'h00000080};
    vt[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h123480FF, 2'd1, 4'h0, 32'h0,        32'h123480FF};
    vt[8]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h123480FF, 2'd1, 4'h0, 32'h0,        32'h00000034};
    vt[9]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h8001ABCD, 2'd1, 4'h0, 32'h0,        32'hFFFF8001};
    vt[10] = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h8001ABCD, 2'd1, 4'h0, 32'h0,        32'h00008001};
    vt[11] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h8001ABCD, 2'd1, 4'h0, 32'h0,        32'hFFFFABCD};
    vt[12] = '{1'b0, 3'b100, 32'h100, 32'h0,        32'h8001ABCD, 2'd1, 4'h0, 32'h0,        32'h000000CD};
    vt[13] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h8001ABCD, 2'd1, 4'h0, 32'h0,        32'hFFFFFF80};
    vt[14] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[15] = '{1'b1, 3'b001, 32'h101, 32'h1234,     32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[16] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[17] = '{1'b1, 3'b100, 32'h100, 32'h55,       32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[18] = '{1'b1, 3'b111, 32'h100, 32'h55,       32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[19] = '{1'b0, 3'b101, 32'h103, 32'h0,        32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[20] = '{1'b0, 3'b110, 32'h000, 32'h0,        32'h5555AAAA, 2'd2, 4'h0, 32'h0,        32'h0};
    vt[21] = '{1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        2'd0, 4'hF, 32'hCAFEF00D, 32'h0};
    vt[22] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h0BADC0DE, 2'd1, 4'h0, 32'h0,        32'h0BADC0DE};

    // Reset with a request pending in the same cycles: request must be dropped.
    rst = 1'b1; req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h100;
    repeat (3) @(negedge clk);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst fault1", 32'(fault1), 32'd0);
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst mem_en1", 32'(mem_en1), 32'd0);
    chk("rst mem_we1", 32'(mem_we1), 32'd0);
    chk("rst mem_addr1", mem_addr1, 32'h0);
    chk("rst mem_wdata1", mem_wdata1, 32'h0);
    chk("rst busy3", 32'(busy3), 32'd0);
    chk("rst mem_en3", 32'(mem_en3), 32'd0);
    chk("rst rdata3", rdata3, 32'h0);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post-rst busy1", 32'(busy1), 32'd0);
    chk("post-rst busy3", 32'(busy3), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset while the latency-3 unit is in WAIT: request dropped, rdata cleared, no done.
    chk("pre-abort rdata3", rdata3, exp_rd);
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h100; mem_word = 32'h123480FF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("abort busy3 in wait", 32'(busy3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy3", 32'(busy3), 32'd0);
    chk("abort rdata3", rdata3, 32'h0);
    chk("abort mem_en3", 32'(mem_en3), 32'd0);
    chk("abort mem_we3", 32'(mem_we3), 32'd0);
    chk("abort busy1", 32'(busy1), 32'd0);
    chk("abort rdata1", rdata1, 32'h0);
    n1 = 32'(done1); n3 = 32'(done3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n1 += 32'(done1); n3 += 32'(done3);
    end
    chk("abort done1 pulses", n1, 0);
    chk("abort done3 pulses", n3, 0);
    exp_rd = 32'h0;

    // req held through ISSUE and DONE, dropped before IDLE: only one access.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h200; wdata = 32'h11223344;
    e1 = 0; e3 = 0; n1 = 0; n3 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) req = 1'b0;
      e1 += 32'(mem_en1); e3 += 32'(mem_en3);
      n1 += 32'(done1);   n3 += 32'(done3);
    end
    chk("busy-req mem_en1 count", e1, 1);
    chk("busy-req mem_en3 count", e3, 1);
    chk("busy-req done1 count", n1, 1);
    chk("busy-req done3 count", n3, 1);

    // req held into the IDLE cycle after DONE: a second access issues in cycle 4.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h201; wdata = 32'h0000005A;
    e1 = 0; e3 = 0; n1 = 0; en4 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 4) begin
        req = 1'b0;
        en4 = 32'(mem_en1);
        chk("b2b mem_we1", 32'(mem_we1), 32'h2);
        chk("b2b mem_wdata1", mem_wdata1, 32'h5A5A5A5A);
      end
      e1 += 32'(mem_en1); e3 += 32'(mem_en3); n1 += 32'(done1);
    end
    chk("b2b mem_en1 in cycle 4", en4, 1);
    chk("b2b mem_en1 count", e1, 2);
    chk("b2b mem_en3 count", e3, 2);
    chk("b2b done1 count", n1, 2);
    chk("b2b rdata1 unchanged", rdata1, exp_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
